sam_key_sequencer: RTL and testbench

SAM_KEY_SEQUENCER -- requirements
Module: sam_key_sequencer

---
 rtl/sam_key_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_sam_key_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sam_key_sequencer.sv
// sam_key_sequencer: shifts a 20-bit key (N, d, capsN) into the decryption
// module under mode=1. It then inserts a one-cycle gap and passes the serial
// message through until stop is seen or the watchdog expires.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start                  load request (sampled only in IDLE)
//   n_cfg/d_cfg/caps_cfg   key fields, shifted MSB first
//   msg_in, stop           serial message bit and session end request
//   frame                  frame indication from the decryption module
//   timeout_cfg            watchdog limit in PASS cycles (0 disables it)
//   str, mode              serial stream and key-load qualifier
//   busy, loaded, err      status: not idle, first PASS cycle pulse, watchdog error
//   frame_cnt              saturating count of frame rising edges in the session
module sam_key_sequencer #(
  parameter logic        IDLE_STR = 1'b1,
  parameter int unsigned TO_W     = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      n_cfg,
  input  logic [7:0]      d_cfg,
  input  logic [7:0]      caps_cfg,
  input  logic            msg_in,
  input  logic            stop,
  input  logic            frame,
  input  logic [TO_W-1:0] timeout_cfg,
  output logic            str,
  output logic            mode,
  output logic            busy,
  output logic            loaded,
  output logic            err,
  output logic [7:0]      frame_cnt
);

  localparam int unsigned N_W   = 4;
  localparam int unsigned D_W   = 8;
  localparam int unsigned C_W   = 8;
  localparam int unsigned KEY_W = N_W + D_W + C_W;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_N = 3'd1;
  localparam logic [2:0] S_LOAD_D = 3'd2;
  localparam logic [2:0] S_LOAD_C = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_PASS   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic             frame_prev_q;
  logic             str_q, str_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             loaded_q, loaded_d;
  logic             err_q, err_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             frame_rise;

  assign frame_rise = frame & ~frame_prev_q;

  // Next state and next output values. The outputs describe the state being
  // entered, so each output is registered and lines up with state_q.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    bit_cnt_d   = bit_cnt_q;
    wd_d        = wd_q;
    str_d       = IDLE_STR;
    mode_d      = 1'b0;
    loaded_d    = 1'b0;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // The shadow copy is shifted left each load cycle, so its MSB is
          // always the bit on str. The first bit comes straight from n_cfg.
          shadow_d    = {n_cfg, d_cfg, caps_cfg};
          bit_cnt_d   = '0;
          err_d       = 1'b0;
          frame_cnt_d = '0;
          state_d     = S_LOAD_N;
          mode_d      = 1'b1;
          str_d       = n_cfg[N_W-1];
        end
      end

      S_LOAD_N, S_LOAD_D, S_LOAD_C: begin
        // bit_cnt_q indexes the key bit currently on str (0..19).
        if (bit_cnt_q == CNT_W'(KEY_W - 1)) begin
          state_d = S_GAP;
          str_d   = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          shadow_d  = shadow_q << 1;
          str_d     = shadow_q[KEY_W-2];
          mode_d    = 1'b1;
          if (bit_cnt_d == CNT_W'(N_W)) begin
            state_d = S_LOAD_D;
          end else if (bit_cnt_d == CNT_W'(N_W + D_W)) begin
            state_d = S_LOAD_C;
          end
        end
      end

      S_GAP: begin
        state_d  = S_PASS;
        loaded_d = 1'b1;
        str_d    = msg_in;
        wd_d     = TO_W'(1);
      end

      S_PASS: begin
        if (frame_rise && (frame_cnt_q != 8'hFF)) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
        // stop outranks the watchdog. A frame edge restarts the count.
        if (stop) begin
          state_d = S_IDLE;
        end else if (frame_rise) begin
          wd_d  = TO_W'(1);
          str_d = msg_in;
        end else if ((timeout_cfg != '0) && (wd_q >= timeout_cfg)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          if (wd_q != '1) begin
            wd_d = wd_q + TO_W'(1);
          end
          str_d = msg_in;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shadow_q     <= '0;
      bit_cnt_q    <= '0;
      wd_q         <= '0;
      frame_prev_q <= 1'b0;
      str_q        <= IDLE_STR;
      mode_q       <= 1'b0;
      busy_q       <= 1'b0;
      loaded_q     <= 1'b0;
      err_q        <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      bit_cnt_q    <= bit_cnt_d;
      wd_q         <= wd_d;
      frame_prev_q <= frame;
      str_q        <= str_d;
      mode_q       <= mode_d;
      busy_q       <= busy_d;
      loaded_q     <= loaded_d;
      err_q        <= err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign str       = str_q;
  assign mode      = mode_q;
  assign busy      = busy_q;
  assign loaded    = loaded_q;
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sam_key_sequencer.sv
// Testbench for sam_key_sequencer. It runs directed scenarios and random traffic
// and compares the outputs every cycle against a queue-based session model.
module tb_sam_key_sequencer;

  localparam int unsigned TO_W = 16;

  logic            clk = 1'b0;
  logic            reset, start, msg_in, stop, frame;
  logic [3:0]      n_cfg;
  logic [7:0]      d_cfg, caps_cfg;
  logic [TO_W-1:0] timeout_cfg;
  logic            str, mode, busy, loaded, err;
  logic [7:0]      frame_cnt;

  sam_key_sequencer #(.IDLE_STR(1'b1), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset), .start(start), .n_cfg(n_cfg), .d_cfg(d_cfg),
    .caps_cfg(caps_cfg), .msg_in(msg_in), .stop(stop), .frame(frame),
    .timeout_cfg(timeout_cfg), .str(str), .mode(mode), .busy(busy),
    .loaded(loaded), .err(err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Session model. A start queues the 20 key bits plus the gap as {mode,str}
  // pairs. PASS is a plain cycle counter with frame edges and a watchdog.
  logic [1:0] m_q[$];
  int   m_phase = 0;   // 0 idle, 1 loading, 2 passing
  int   m_wd    = 0;
  int   m_fcnt  = 0;
  logic m_str   = 1'b1;
  logic m_mode  = 1'b0;
  logic m_loaded = 1'b0;
  logic m_err   = 1'b0;
  logic m_prev  = 1'b0;

  always @(posedge clk) begin
    logic        rise;
    logic [19:0] key;
    rise     = frame && !m_prev;
    m_prev   = frame;
    m_loaded = 1'b0;
    if (reset) begin
      m_phase = 0; m_q.delete(); m_str = 1'b1; m_mode = 1'b0;
      m_err = 1'b0; m_fcnt = 0; m_prev = 1'b0; m_wd = 0;
    end else begin
      case (m_phase)
        0: begin
          m_str = 1'b1; m_mode = 1'b0;
          if (start) begin
            key = {n_cfg, d_cfg, caps_cfg};
            for (int i = 19; i >= 0; i--) m_q.push_back({1'b1, key[i]});
            m_q.push_back(2'b00);
            m_err = 1'b0; m_fcnt = 0;
            {m_mode, m_str} = m_q.pop_front();
            m_phase = 1;
          end
        end
        1: begin
          if (m_q.size() > 0) {m_mode, m_str} = m_q.pop_front();
          else begin
            m_phase = 2; m_loaded = 1'b1; m_mode = 1'b0; m_str = msg_in; m_wd = 1;
          end
        end
        default: begin
          if (rise && m_fcnt < 255) m_fcnt++;
          if (stop) begin
            m_phase = 0; m_str = 1'b1;
          end else if (rise) begin
            m_wd = 1; m_str = msg_in;
          end else if (timeout_cfg != 0 && m_wd >= int'(timeout_cfg)) begin
            m_err = 1'b1; m_phase = 0; m_str = 1'b1;
          end else begin
            m_wd++; m_str = msg_in;
          end
        end
      endcase
    end
    #1;
    if (chk_en)
      check("cycle_outputs", {19'd0, str, mode, busy, loaded, err, frame_cnt},
            {19'd0, m_str, m_mode, 1'(m_phase != 0), m_loaded, m_err, 8'(m_fcnt)});
  end

  // Called at a negedge while idle. Returns at the negedge of the gap cycle,
  // with the 20 str bits and the AND of mode over the load cycles.
  // The config inputs are scrambled after acceptance, and start is pulsed
  // again on load cycle ign_at+1 (a negative value means no pulse).
  task automatic start_load(input logic [3:0] n, input logic [7:0] d, input logic [7:0] c,
                            input int ign_at, output logic [19:0] bits, output logic mode_ok);
    n_cfg = n; d_cfg = d; caps_cfg = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cfg = 4'($urandom); d_cfg = 8'($urandom); caps_cfg = 8'($urandom);
    bits = '0; mode_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bits    = {bits[18:0], str};
      mode_ok = mode_ok & mode;
      start   = (i == ign_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic end_session();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  initial begin
    logic [19:0] bits;
    logic        mok;
    logic [3:0]  rn;
    logic [7:0]  rd, rc;
    logic [3:0]  got;
    logic [3:0]  pat;
    int          cnt;
    bit          done;

    reset = 1'b1; start = 1'b0; n_cfg = '0; d_cfg = '0; caps_cfg = '0;
    msg_in = 1'b0; stop = 1'b0; frame = 1'b0; timeout_cfg = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_state", {19'd0, str, mode, busy, loaded, err, frame_cnt}, {19'd0, 1'b1, 12'd0});
    reset = 1'b0;
    @(negedge clk);

    // Known key, with a start pulse during LOAD_D that must be ignored.
    start_load(4'h3, 8'hA5, 8'h3C, 6, bits, mok);
    check("load_bits", 32'(bits), 32'(20'b0011_1010_0101_0011_1100));
    check("load_mode", 32'(mok), 32'd1);
    check("gap_cycle", {30'd0, mode, str}, 32'd0);
    pat = 4'b1101;
    msg_in = pat[3];
    got = '0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j == 0) check("loaded_pulse", 32'(loaded), 32'd1);
      got = {got[2:0], str};
      if (j < 3) msg_in = pat[2-j];
    end
    check("pass_through", 32'(got), 32'(pat));
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("stop_idle", {29'd0, str, busy, mode}, {29'd0, 3'b100});

    // Reset in the middle of the key, then a full reload.
    n_cfg = 4'hF; d_cfg = 8'hFF; caps_cfg = 8'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("reset_midload", {29'd0, mode, str, busy}, {29'd0, 3'b010});
    rn = 4'($urandom); rd = 8'($urandom); rc = 8'($urandom);
    start_load(rn, rd, rc, -1, bits, mok);
    check("reload_bits", 32'(bits), 32'({rn, rd, rc}));
    end_session();

    // Watchdog expiry without frames.
    timeout_cfg = TO_W'(5);
    start_load(4'h1, 8'h22, 8'h33, -1, bits, mok);
    cnt = 0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (busy) cnt++; else done = 1'b1;
    end
    check("wd_pass_cycles", 32'(cnt), 32'd5);
    check("wd_err", 32'(err), 32'd1);

    // Frames every 3 cycles keep the watchdog away.
    start_load(4'h2, 8'h44, 8'h55, -1, bits, mok);
    check("err_cleared", 32'(err), 32'd0);
    @(negedge clk);
    for (int p = 0; p < 10; p++) begin
      frame = 1'b1; @(negedge clk);
      frame = 1'b0; @(negedge clk); @(negedge clk);
    end
    check("frames_no_err", {30'd0, err, busy}, {30'd0, 2'b01});
    check("frame_cnt_10", 32'(frame_cnt), 32'd10);
    end_session();
    check("frame_cnt_hold", 32'(frame_cnt), 32'd10);

    // Saturation at 255 frame edges.
    timeout_cfg = '0;
    start_load(4'h5, 8'h66, 8'h77, -1, bits, mok);
    @(negedge clk);
    for (int p = 0; p < 300; p++) begin
      frame = 1'b1; @(negedge clk);
      frame = 1'b0; @(negedge clk);
    end
    check("frame_cnt_sat", 32'(frame_cnt), 32'd255);
    end_session();

    // stop and watchdog expiry on the same edge.
    timeout_cfg = TO_W'(1);
    start_load(4'h9, 8'h88, 8'h99, -1, bits, mok);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("stop_beats_wd", {30'd0, busy, err}, 32'd0);

    // Random traffic checked only by the model.
    for (int c = 0; c < 5000; c++) begin
      if (c % 400 == 0) timeout_cfg = TO_W'($urandom_range(0, 40));
      start    = ($urandom_range(0, 9) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      frame    = ($urandom_range(0, 2) == 0);
      msg_in   = 1'($urandom);
      reset    = ($urandom_range(0, 299) == 0);
      n_cfg    = 4'($urandom);
      d_cfg    = 8'($urandom);
      caps_cfg = 8'($urandom);
      @(negedge clk);
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0; frame = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
